// File: rtl/raydiv_pkg.sv
// raydiv_pkg: shared definitions for the raydiv restoring divider.
//   state_t       - FSM state encoding (IDLE / BUSY / DONE)
//   DEFAULT_WIDTH - default operand / result width in bits
package raydiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/raydiv_step.sv
// raydiv_step: one combinational restoring-division step.
// The partial remainder is shifted left by one, the next dividend bit is
// brought in, and the divisor is subtracted when it fits.
// Ports:
//   rem_in  [WIDTH:0]   - partial remainder before this step
//   dvd_bit             - next dividend bit (MSB first)
//   divisor [WIDTH-1:0] - captured divisor
//   rem_out [WIDTH:0]   - partial remainder after this step
//   q_bit               - quotient bit produced by this step
module raydiv_step import raydiv_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] div_ext;
  logic           fits;

  assign shifted = {rem_in[WIDTH-1:0], dvd_bit};
  assign div_ext = {1'b0, divisor};
  // A set top bit before the shift means the shifted value exceeds any
  // WIDTH-bit divisor; with a reduced remainder it never happens, but it
  // keeps the step correct for any input.
  assign fits    = rem_in[WIDTH] | (shifted >= div_ext);
  assign rem_out = fits ? (shifted - div_ext) : shifted;
  assign q_bit   = fits;

endmodule

// File: rtl/raydiv.sv
// raydiv: sequential unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (prod = dividend, in1 = divisor)
//   out_valid/out_ready - result handshake (in2 = quotient, rem = remainder,
//                         div_zero = accepted divisor was zero)
//   state               - current FSM state, for debug visibility
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; results stay
// stable while out_valid is high and out_ready is low.
module raydiv import raydiv_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] prod,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [WIDTH-1:0] dvd;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr;       // captured divisor
  logic [WIDTH:0]   preg;      // partial remainder
  logic [WIDTH:0]   preg_nxt;
  logic [CW-1:0]    cnt;
  logic             q_bit;
  logic             last_step;
  logic             accept;
  logic [WIDTH-1:0] in2_r;
  logic [WIDTH-1:0] rem_r;
  logic             dz_r;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(WIDTH - 1));

  raydiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (preg),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dsr),
    .rem_out (preg_nxt),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: if (in_valid) nxt_state = (in1 == '0) ? DONE : BUSY;
      BUSY: if (last_step) nxt_state = DONE;
      DONE: if (out_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (cur_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, iterate in BUSY, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd   <= '0;
      dsr   <= '0;
      preg  <= '0;
      cnt   <= '0;
      in2_r <= '0;
      rem_r <= '0;
      dz_r  <= 1'b0;
    end else if (accept) begin
      dvd  <= prod;
      dsr  <= in1;
      preg <= '0;
      cnt  <= '0;
      if (in1 == '0) begin
        in2_r <= '1;
        rem_r <= prod;
        dz_r  <= 1'b1;
      end else begin
        dz_r  <= 1'b0;
      end
    end else if (cur_state == BUSY) begin
      dvd  <= {dvd[WIDTH-2:0], q_bit};
      preg <= preg_nxt;
      cnt  <= cnt + 1'b1;
      if (last_step) begin
        in2_r <= {dvd[WIDTH-2:0], q_bit};
        // The reduced remainder is below the divisor, so its top bit is 0.
        rem_r <= preg_nxt[WIDTH-1:0];
      end
    end
  end

  assign in2      = in2_r;
  assign rem      = rem_r;
  assign div_zero = dz_r;
  assign state    = cur_state;

endmodule

// File: tb/tb_raydiv.sv
// tb_raydiv: self-checking bench for raydiv (WIDTH=8). Expected results are
// computed with / and % when an operand pair is accepted, queued, and
// compared when the DUT hands the result over.
module tb_raydiv;

  localparam int W = 8;
  localparam int R = 2 * W + 1;  // {in2, rem, div_zero}

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod = '0;
  logic [W-1:0] in1 = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] in2;
  logic [W-1:0] rem;
  logic         div_zero;
  logic [1:0]   state;

  int checks = 0;
  int failures = 0;
  logic [R-1:0] exp_q[$];

  raydiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in2       (in2),
    .rem       (rem),
    .div_zero  (div_zero),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [R-1:0] model(input logic [W-1:0] p, input logic [W-1:0] d);
    if (d == '0) return {{W{1'b1}}, p, 1'b1};
    return {W'(p / d), W'(p % d), 1'b0};
  endfunction

  function automatic logic [R-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Drive one operand pair and wait for the accept edge; returns at edge+1.
  task automatic accept_op(input logic [W-1:0] p, input logic [W-1:0] d);
    int n;
    @(negedge clk);
    prod = p;
    in1 = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      exp_q.push_back(model(p, d));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prod = W'($urandom);
    in1 = W'($urandom);
  endtask

  // Edges counted from the accept edge (inclusive) to the out_valid edge.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic collect(output logic [R-1:0] got);
    @(negedge clk);
    got = {in2, rem, div_zero};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, in2, rem, div_zero, state} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_async: rdy=%b ov=%b in2=%h rem=%h dz=%b st=%0d required 1 0 00 00 0 0",
               in_ready, out_valid, in2, rem, div_zero, state);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, in2, rem, div_zero, state} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_held: rdy=%b ov=%b in2=%h rem=%h dz=%b st=%0d required 1 0 00 00 0 0",
               in_ready, out_valid, in2, rem, div_zero, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [R-1:0] got, exp;
    accept_op(8'd100, 8'd7);
    wait_out(lat);
    checks++;
    if (lat !== W + 1) begin
      failures++;
      $display("FAIL basic_latency: got %0d required %0d", lat, W + 1);
    end
    collect(got);
    exp = pop_exp();
    checks++;
    if (got !== exp || exp !== {8'd14, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL basic_result: got %h required %h", got, {8'd14, 8'd2, 1'b0});
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL basic_return_idle: rdy/ov=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] tp[4] = '{8'd255, 8'd255, 8'd0, 8'd4};
    logic [W-1:0] td[4] = '{8'd1, 8'd255, 8'd9, 8'd200};
    int lat;
    logic [R-1:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      accept_op(tp[i], td[i]);
      wait_out(lat);
      checks++;
      if (lat !== W + 1) begin
        failures++;
        $display("FAIL edge_latency[%0d]: got %0d required %0d", i, lat, W + 1);
      end
      collect(got);
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL edge_result[%0d] %0d/%0d: got %h required %h", i, tp[i], td[i], got, exp);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [R-1:0] got, exp;
    accept_op(8'd5, 8'd0);
    wait_out(lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL divzero_latency: got %0d required 1", lat);
    end
    collect(got);
    exp = pop_exp();
    checks++;
    if (got !== exp || exp !== {8'hFF, 8'd5, 1'b1}) begin
      failures++;
      $display("FAIL divzero_result: got %h required %h", got, {8'hFF, 8'd5, 1'b1});
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [R-1:0] got, exp;
    accept_op(8'd3, 8'd10);
    wait_out(lat);
    checks++;
    if (lat !== W + 1) begin
      failures++;
      $display("FAIL stall_latency: got %0d required %0d", lat, W + 1);
    end
    exp = model(8'd3, 8'd10);
    // Offer a competing operand while stalled; it must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      prod = W'($urandom);
      in1 = W'($urandom);
      checks++;
      if ({in2, rem, div_zero} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: out=%h rdy=%b ov=%b required %h 0 1",
                 i, {in2, rem, div_zero}, in_ready, out_valid, exp);
      end
    end
    // in_valid stays high across the output handshake edge.
    collect(got);
    checks++;
    if (got !== pop_exp()) begin
      failures++;
      $display("FAIL stall_result: got %h required %h", got, exp);
    end
    checks++;
    if ({in_ready, state} !== {1'b1, 2'd0}) begin
      failures++;
      $display("FAIL no_accept_on_release: rdy=%b st=%0d required 1 0", in_ready, state);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat, seen;
    logic [R-1:0] got, exp;
    accept_op(8'd200, 8'd9);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, state} !== {1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL abort_async: rdy=%b ov=%b st=%0d required 1 0 0", in_ready, out_valid, state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_stale: out_valid seen %0d cycles required 0", seen);
    end
    accept_op(8'd200, 8'd9);
    wait_out(lat);
    checks++;
    if (lat !== W + 1) begin
      failures++;
      $display("FAIL abort_next_latency: got %0d required %0d", lat, W + 1);
    end
    collect(got);
    exp = pop_exp();
    checks++;
    if (got !== exp || exp !== {8'd22, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL abort_next_result: got %h required %h", got, {8'd22, 8'd2, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int nres, last_cyc;
    logic acc, vout;
    logic [R-1:0] exp;
    nres = 0;
    last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc < 40) begin
        in_valid = 1'b1;
        prod = W'($urandom);
        in1 = W'($urandom_range(1, 255));
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      vout = out_valid && out_ready;
      if (acc) exp_q.push_back(model(prod, in1));
      if (vout) begin
        exp = pop_exp();
        checks++;
        if ({in2, rem, div_zero} !== exp) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got %h required %h", nres, {in2, rem, div_zero}, exp);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc !== W + 2) begin
            failures++;
            $display("FAIL b2b_period: got %0d required %0d", cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        nres++;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (nres !== 4 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count: results=%0d pending=%0d required 4 0", nres, exp_q.size());
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] p, d;
    logic [R-1:0] got, exp;
    logic [2*W-1:0] recon;
    for (int i = 0; i < 1000; i++) begin
      p = W'($urandom_range(0, 255));
      d = W'($urandom_range(1, 255));
      accept_op(p, d);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      collect(got);
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand_result[%0d] %0d/%0d: got %h required %h", i, p, d, got, exp);
      end
      recon = (2*W)'(got[R-1:W+1]) * (2*W)'(d) + (2*W)'(got[W:1]);
      checks++;
      if (recon !== (2*W)'(p) || got[W:1] >= d || got[0] !== 1'b0) begin
        failures++;
        $display("FAIL rand_identity[%0d]: in2*in1+rem=%0d rem=%0d dz=%b required %0d <%0d 0",
                 i, recon, got[W:1], got[0], p, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
